// File: rtl/find_max_feeder.sv
// Frame feeder for the max-finder stage: collects a header plus up to seven
// 4-byte entries, then replays them as start / valid strobes followed by a drain gap.
module find_max_feeder #(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       start,
  output logic       valid,
  output logic [2:0] count,
  output logic [2:0] select,
  output logic [7:0] instruction,
  output logic [7:0] data_A,
  output logic [7:0] data_B,
  output logic [7:0] data_C,
  output logic       frame_done,
  output logic       hdr_err,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, LOAD, START, ISSUE, DRAIN} state_t;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t          state_q, state_d;
  logic [4:0]      byte_cnt_q;
  logic [2:0]      issue_idx_q;
  logic [DW-1:0]   drain_cnt_q;
  logic [3:0][7:0] buf_mem [7];

  logic       accept, last_byte, last_entry, last_drain;
  logic       in_ready_d, start_d, valid_d, frame_done_d, hdr_err_d, busy_d;
  logic [2:0] count_d, select_d, rd_idx;
  logic [3:0][7:0] entry_d;

  assign accept     = in_valid && in_ready;
  assign last_byte  = byte_cnt_q == ({count, 2'b00} - 5'd1);
  assign last_entry = issue_idx_q == (count - 3'd1);
  assign last_drain = drain_cnt_q == DW'(DRAIN_CYCLES - 1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept && in_data[2:0] != 3'd0) state_d = LOAD;
      LOAD:  if (accept && last_byte) state_d = START;
      START: state_d = ISSUE;
      ISSUE: if (last_entry) state_d = (DRAIN_CYCLES == 0) ? IDLE : DRAIN;
      DRAIN: if (last_drain) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output values are decoded from the next state and registered, so each
  // output lines up with the state it belongs to.
  always_comb begin
    in_ready_d   = (state_d == IDLE) || (state_d == LOAD);
    start_d      = state_d == START;
    valid_d      = state_d == ISSUE;
    busy_d       = state_d != IDLE;
    frame_done_d = (state_q == ISSUE || state_q == DRAIN) && state_d == IDLE;
    hdr_err_d    = state_q == IDLE && accept && in_data[2:0] == 3'd0;
    count_d      = count;
    select_d     = select;
    if (state_q == IDLE && state_d == LOAD) begin
      count_d  = in_data[2:0];
      select_d = in_data[5:3];
    end
    rd_idx  = (state_q == ISSUE) ? issue_idx_q + 3'd1 : 3'd0;
    entry_d = {data_C, data_B, data_A, instruction};
    if (state_d == ISSUE) entry_d = buf_mem[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready    <= 1'b0;
      start       <= 1'b0;
      valid       <= 1'b0;
      frame_done  <= 1'b0;
      hdr_err     <= 1'b0;
      busy        <= 1'b0;
      count       <= '0;
      select      <= '0;
      instruction <= '0;
      data_A      <= '0;
      data_B      <= '0;
      data_C      <= '0;
    end else begin
      in_ready    <= in_ready_d;
      start       <= start_d;
      valid       <= valid_d;
      frame_done  <= frame_done_d;
      hdr_err     <= hdr_err_d;
      busy        <= busy_d;
      count       <= count_d;
      select      <= select_d;
      instruction <= entry_d[0];
      data_A      <= entry_d[1];
      data_B      <= entry_d[2];
      data_C      <= entry_d[3];
    end
  end

  // NOTE: the entry buffer is small and must read as zero after reset, so it
  // sits in the async reset domain instead of being left uninitialised like a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) buf_mem[i] <= '0;
      byte_cnt_q  <= '0;
      issue_idx_q <= '0;
      drain_cnt_q <= '0;
    end else begin
      if (state_q == IDLE && state_d == LOAD) byte_cnt_q <= '0;
      if (state_q == LOAD && accept) begin
        buf_mem[byte_cnt_q[4:2]][byte_cnt_q[1:0]] <= in_data;
        byte_cnt_q <= byte_cnt_q + 5'd1;
      end
      if (state_d == START) issue_idx_q <= '0;
      else if (state_q == ISSUE && state_d == ISSUE) issue_idx_q <= issue_idx_q + 3'd1;
      if (state_q != DRAIN) drain_cnt_q <= '0;
      else                  drain_cnt_q <= drain_cnt_q + DW'(1);
    end
  end

endmodule
